// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions.
//   ADDR_W / DATA_W / RESET_PC : default widths and reset fetch address.
//   fetch_entry_t              : {pc, instr} pair carried through the fetch queue.
package cpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundle of the fetch stage's memory, control and decoder signals.
//   master : fetch stage side (drives mem_addr, out_valid, out_instr, out_pc).
//   slave  : environment side (memory, control and decoder).
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W = cpu_pkg::DATA_W
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_busy;
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output mem_addr,
        input  mem_data, mem_busy, halt, redirect_valid, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc
    );

    modport slave (
        input  mem_addr,
        output mem_data, mem_busy, halt, redirect_valid, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : empties the FIFO at the edge; overrides push/pop
//   push, wdata    : write at tail (accepted when not full, or full with pop)
//   pop, rdata     : rdata shows the head combinationally; pop advances it
//   full, empty    : status
//   count          : occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = pop & ~empty;
    // When full, a push only fits if the head is leaving in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : instr_fetch_if.master
//                mem_addr (=pc) / mem_data / mem_busy : program-memory port
//                halt, redirect_valid, redirect_pc    : fetch control
//                out_valid / out_ready / out_instr / out_pc : decoder handshake
// Fetched {pc, word} pairs are queued in a prefetch FIFO; a redirect flushes
// the queue and reloads pc.
module instr_fetch #(
    parameter int unsigned       ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned       DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = FIFO_DEPTH[CNT_W-1:0];

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              fetch;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    entry_t            wr_entry;
    entry_t            rd_entry;

    // Redirect masks both the pop and the fetch: the queue is being discarded.
    assign pop   = ~empty & bus.out_ready & ~bus.redirect_valid;
    assign fetch = ~bus.redirect_valid & ~bus.mem_busy & ~bus.halt & (~full | pop);

    assign wr_entry = {pc, bus.mem_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc;
        end else if (fetch) begin
            pc <= pc + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .push  (fetch),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.mem_addr  = pc;
    assign bus.out_valid = ~empty & ~bus.redirect_valid;
    assign bus.out_instr = rd_entry.instr;
    assign bus.out_pc    = rd_entry.pc;

    full_matches_count: assert property (
        @(posedge clk) disable iff (!rst_n) full == (count == CNT_FULL)
    );

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        t_busy = 1'b0;
    logic        t_halt = 1'b1;
    logic        t_rv = 1'b0;
    logic [15:0] t_rpc = 16'h0;
    logic        t_ready = 1'b0;

    int total = 0;
    int bad = 0;

    // reference model: next fetch address and queue of fetched addresses
    int m_pc = 0;
    int m_q[$];

    instr_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus0 ();
    instr_fetch_if #(.ADDR_W(16), .DATA_W(32)) bus1 ();

    assign bus0.mem_data = 32'hA000_0000 + {16'h0, bus0.mem_addr};
    assign bus1.mem_data = 32'hA000_0000 + {16'h0, bus1.mem_addr};
    assign bus0.mem_busy = t_busy;
    assign bus1.mem_busy = t_busy;
    assign bus0.halt = t_halt;
    assign bus1.halt = t_halt;
    assign bus0.redirect_valid = t_rv;
    assign bus1.redirect_valid = t_rv;
    assign bus0.redirect_pc = t_rpc;
    assign bus1.redirect_pc = t_rpc;
    assign bus0.out_ready = t_ready;
    assign bus1.out_ready = t_ready;

    instr_fetch #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    instr_fetch #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .RESET_PC(16'hFFFE)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    task automatic drive(input logic busy, input logic hlt, input logic rv,
                         input logic [15:0] rpc, input logic rdy);
        t_busy = busy; t_halt = hlt; t_rv = rv; t_rpc = rpc; t_ready = rdy;
    endtask

    // one clock edge of the behavioural model for dut0
    task automatic model_edge();
        bit pop;
        bit fetch;
        if (t_rv) begin
            m_q.delete();
            m_pc = int'(t_rpc);
            return;
        end
        pop = (m_q.size() != 0) && t_ready;
        fetch = !t_busy && !t_halt && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (fetch) begin
            m_q.push_back(m_pc);
            m_pc = (m_pc + 1) % 65536;
        end
    endtask

    // reset with halt asserted so the first edge after release fetches nothing
    task automatic apply_reset();
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_pc = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus0.out_valid); end
        total++; if (bus0.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr0 got=%h exp=0000", bus0.mem_addr); end
        total++; if (bus1.mem_addr !== 16'hFFFE) begin bad++; $display("FAIL reset_addr1 got=%h exp=fffe", bus1.mem_addr); end
        // reset held across active edges with fetch conditions otherwise met
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid got=%b exp=0", bus0.out_valid); end
        total++; if (bus0.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_hold_addr got=%h exp=0000", bus0.mem_addr); end
        apply_reset();
    endtask

    task automatic test_stream();
        int nexp = 0;
        bit exp_v;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp_v = (m_q.size() != 0) && !t_rv;
            total++; if (bus0.out_valid !== exp_v) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, bus0.out_valid, exp_v); end
            total++; if (bus0.mem_addr !== 16'(m_pc)) begin bad++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", i, bus0.mem_addr, 16'(m_pc)); end
            if (i > 0) begin
                total++;
                if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 16'(nexp) || bus0.out_instr !== 32'hA000_0000 + 32'(nexp)) begin
                    bad++; $display("FAIL stream_seq cyc=%0d got v=%b pc=%h instr=%h exp pc=%h", i, bus0.out_valid, bus0.out_pc, bus0.out_instr, 16'(nexp));
                end
                nexp++;
            end
            model_edge();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int popped[$];
        bit exp_v;
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = (m_q.size() != 0);
            total++; if (bus0.out_valid !== exp_v) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", i, bus0.out_valid, exp_v); end
            total++; if (bus0.mem_addr !== 16'(m_pc)) begin bad++; $display("FAIL bp_addr cyc=%0d got=%h exp=%h", i, bus0.mem_addr, 16'(m_pc)); end
            model_edge();
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (bus0.mem_addr !== 16'h0004) begin bad++; $display("FAIL bp_frozen_addr got=%h exp=0004", bus0.mem_addr); end
        total++; if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 16'h0000) begin bad++; $display("FAIL bp_head got v=%b pc=%h exp v=1 pc=0000", bus0.out_valid, bus0.out_pc); end
        @(posedge clk); #1;
        t_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus0.out_valid === 1'b1) popped.push_back(int'(bus0.out_pc));
            model_edge();
            @(posedge clk); #1;
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (k >= popped.size()) begin
                bad++; $display("FAIL bp_drain idx=%0d got=none exp=%0d", k, k);
            end else if (popped[k] != k) begin
                bad++; $display("FAIL bp_drain idx=%0d got=%0d exp=%0d", k, popped[k], k);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) begin model_edge(); @(posedge clk); #1; end
        drive(1'b0, 1'b0, 1'b1, 16'h0100, 1'b1);
        @(negedge clk);
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_n got=%b exp=0", bus0.out_valid); end
        model_edge(); @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_n1 got=%b exp=0", bus0.out_valid); end
        total++; if (bus0.mem_addr !== 16'h0100) begin bad++; $display("FAIL redir_addr got=%h exp=0100", bus0.mem_addr); end
        model_edge(); @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 16'h0100 + 16'(k) || bus0.out_instr !== 32'hA000_0100 + 32'(k)) begin
                bad++; $display("FAIL redir_out k=%0d got v=%b pc=%h instr=%h exp pc=%h", k, bus0.out_valid, bus0.out_pc, bus0.out_instr, 16'h0100 + 16'(k));
            end
            model_edge(); @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b0, 1'b1, 16'h2000, 1'b1);
        model_edge(); @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 16'h3000, 1'b1);
        model_edge(); @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        model_edge(); @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 16'h3000) begin
            bad++; $display("FAIL b2b_redirect got v=%b pc=%h exp v=1 pc=3000", bus0.out_valid, bus0.out_pc);
        end
        model_edge(); @(posedge clk); #1;
    endtask

    task automatic test_busy_halt();
        int popped[$];
        logic [15:0] addr_hold;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'(i % 2), 1'b0, 1'b0, 16'h0, 1'b1);
            @(negedge clk);
            total++; if (bus0.out_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL busy_valid cyc=%0d got=%b exp=%b", i, bus0.out_valid, m_q.size() != 0); end
            if (bus0.out_valid === 1'b1) popped.push_back(int'(bus0.out_pc));
            model_edge(); @(posedge clk); #1;
        end
        total++; if (popped.size() != 10) begin bad++; $display("FAIL busy_rate got=%0d exp=10", popped.size()); end
        for (int k = 0; k < popped.size(); k++) begin
            total++; if (popped[k] != k) begin bad++; $display("FAIL busy_seq idx=%0d got=%0d exp=%0d", k, popped[k], k); end
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (3) begin model_edge(); @(posedge clk); #1; end
        drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        addr_hold = bus0.mem_addr;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (bus0.out_valid !== (m_q.size() != 0)) begin bad++; $display("FAIL halt_valid cyc=%0d got=%b exp=%b", i, bus0.out_valid, m_q.size() != 0); end
            total++; if (bus0.mem_addr !== 16'(m_pc)) begin bad++; $display("FAIL halt_addr cyc=%0d got=%h exp=%h", i, bus0.mem_addr, 16'(m_pc)); end
            model_edge(); @(posedge clk); #1;
        end
        @(negedge clk);
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL halt_drained got=%b exp=0", bus0.out_valid); end
        total++; if (bus0.mem_addr !== addr_hold) begin bad++; $display("FAIL halt_addr_stable got=%h exp=%h", bus0.mem_addr, addr_hold); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit exp_v;
        logic [15:0] rpc;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rpc = 16'hFFFE;
                1: rpc = 16'hFFFF;
                default: rpc = 16'($urandom_range(0, 65535));
            endcase
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 6) == 0),
                  1'($urandom_range(0, 19) == 0), rpc, 1'($urandom_range(0, 4) < 3));
            @(negedge clk);
            exp_v = (m_q.size() != 0) && !t_rv;
            total++; if (bus0.out_valid !== exp_v) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, bus0.out_valid, exp_v); end
            total++; if (bus0.mem_addr !== 16'(m_pc)) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus0.mem_addr, 16'(m_pc)); end
            if (exp_v) begin
                total++;
                if (bus0.out_pc !== 16'(m_q[0]) || bus0.out_instr !== 32'hA000_0000 + 32'(m_q[0])) begin
                    bad++; $display("FAIL rnd_head cyc=%0d got pc=%h instr=%h exp pc=%h", i, bus0.out_pc, bus0.out_instr, 16'(m_q[0]));
                end
            end
            model_edge(); @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pcs [4];
        int n = 0;
        exp_pcs[0] = 16'hFFFE; exp_pcs[1] = 16'hFFFF; exp_pcs[2] = 16'h0000; exp_pcs[3] = 16'h0001;
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus1.out_valid === 1'b1 && n < 4) begin
                total++;
                if (bus1.out_pc !== exp_pcs[n] || bus1.out_instr !== 32'hA000_0000 + {16'h0, exp_pcs[n]}) begin
                    bad++; $display("FAIL wrap_seq idx=%0d got pc=%h instr=%h exp pc=%h", n, bus1.out_pc, bus1.out_instr, exp_pcs[n]);
                end
                n++;
            end
            model_edge(); @(posedge clk); #1;
        end
        total++; if (n != 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", n); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (6) begin model_edge(); @(posedge clk); #1; end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", bus0.out_valid); end
        total++; if (bus0.mem_addr !== 16'h0000) begin bad++; $display("FAIL midrst_addr0 got=%h exp=0000", bus0.mem_addr); end
        total++; if (bus1.mem_addr !== 16'hFFFE) begin bad++; $display("FAIL midrst_addr1 got=%h exp=fffe", bus1.mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_pc = 0;
        model_edge();
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (bus0.out_valid !== 1'b1 || bus0.out_pc !== 16'h0000 || bus0.out_instr !== 32'hA000_0000) begin
            bad++; $display("FAIL midrst_refetch got v=%b pc=%h instr=%h exp v=1 pc=0000 instr=a0000000", bus0.out_valid, bus0.out_pc, bus0.out_instr);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_busy_halt();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
